// File: rtl/moore_seq_pkg.sv
// Shared definitions for the Moore sequence generator family:
// FSM state encoding and a binary-to-Gray helper.
package moore_seq_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Widest code the helper supports; callers zero-extend and truncate.
    localparam int GRAY_MAX_W = 32;

    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/moore_seq_bin2gray.sv
// Combinational binary-to-Gray converter of configurable width.
module moore_seq_bin2gray
    import moore_seq_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic [WIDTH-1:0] i_bin,
    output logic [WIDTH-1:0] o_gray
);

    generate
        if (WIDTH < 2 || WIDTH > GRAY_MAX_W) begin : g_bad_width
            $fatal(1, "moore_seq_bin2gray: WIDTH out of range");
        end
    endgenerate

    // Zero extension keeps the MSB unchanged, as Gray coding requires.
    assign o_gray = WIDTH'(bin2gray(GRAY_MAX_W'(i_bin)));

endmodule

// File: rtl/moore_seq_gen.sv
// Parametrised Moore sequence generator: up/down counter with modulus, binary or
// Gray output, synchronous load, start/stop control and optional one-shot stop.
module moore_seq_gen
    import moore_seq_pkg::*;
#(
    parameter int WIDTH   = 3,
    parameter int MAX_VAL = 2**WIDTH - 1,
    parameter int ONESHOT = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             dir,
    input  logic             gray_en,
    input  logic             ld,
    input  logic [WIDTH-1:0] ld_val,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] bin,
    output logic             tc,
    output logic             all_ones,
    output logic             busy,
    output logic             done
);

    generate
        if (MAX_VAL < 1 || MAX_VAL > 2**WIDTH - 1) begin : g_bad_max
            $fatal(1, "moore_seq_gen: MAX_VAL out of range 1..2**WIDTH-1");
        end
    endgenerate

    localparam logic [WIDTH-1:0] MAX_C  = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_C  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam bit               ONE_SHOT_C = (ONESHOT != 0);

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_cnt;
    logic             r_dir;
    logic             r_gray;

    logic [1:0]       w_state_nxt;
    logic [WIDTH-1:0] w_cnt_fsm;
    logic [WIDTH-1:0] w_cnt_ld;
    logic [WIDTH-1:0] w_cnt_nxt;
    logic             w_dir_nxt;
    logic             w_gray_nxt;
    logic             w_at_term;
    logic [WIDTH-1:0] w_gray;

    assign w_at_term = r_dir ? (r_cnt == ZERO_C) : (r_cnt == MAX_C);
    assign w_cnt_ld  = (ld_val > MAX_C) ? MAX_C : ld_val;
    // Load takes priority over whatever the FSM would do to the count.
    assign w_cnt_nxt = ld ? w_cnt_ld : w_cnt_fsm;

    // FSM transitions, start sampling and the per-cycle count step.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_fsm   = r_cnt;
        w_dir_nxt   = r_dir;
        w_gray_nxt  = r_gray;
        if (stop) begin
            w_state_nxt = ST_IDLE;
        end else if (start && (r_state != ST_RUN)) begin
            w_state_nxt = ST_RUN;
            w_dir_nxt   = dir;
            w_gray_nxt  = gray_en;
            w_cnt_fsm   = dir ? MAX_C : ZERO_C;
        end else if ((r_state == ST_RUN) && !ld) begin
            if (w_at_term) begin
                if (ONE_SHOT_C) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_cnt_fsm = r_dir ? MAX_C : ZERO_C;
                end
            end else begin
                w_cnt_fsm = r_dir ? (r_cnt - ONE_C) : (r_cnt + ONE_C);
            end
        end else begin
            w_state_nxt = r_state;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= ZERO_C;
            r_dir   <= 1'b0;
            r_gray  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_dir   <= w_dir_nxt;
            r_gray  <= w_gray_nxt;
        end
    end

    moore_seq_bin2gray #(
        .WIDTH (WIDTH)
    ) u_bin2gray (
        .i_bin  (r_cnt),
        .o_gray (w_gray)
    );

    // With MAX_VAL below 2**WIDTH-1 the Gray sequence is not cyclic at the wrap.
    assign q        = r_gray ? w_gray : r_cnt;
    assign bin      = r_cnt;
    assign tc       = (r_state == ST_RUN) && w_at_term;
    assign all_ones = &q;
    assign busy     = (r_state == ST_RUN);
    assign done     = (r_state == ST_DONE);

endmodule

// File: tb/tb_moore_seq_gen.sv
// Directed bench for moore_seq_gen: a free-running 0..7 instance (A) and a
// one-shot 0..5 instance (B) share stimulus; expectations are hand-computed.
module tb_moore_seq_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       dir = 1'b0;
    logic       gray_en = 1'b0;
    logic       ld = 1'b0;
    logic [2:0] ld_val = 3'd0;

    logic [2:0] a_q, a_bin, b_q, b_bin;
    logic       a_tc, a_all_ones, a_busy, a_done;
    logic       b_tc, b_all_ones, b_busy, b_done;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    moore_seq_gen #(.WIDTH(3), .MAX_VAL(7), .ONESHOT(0)) u_dut_a (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .dir(dir),
        .gray_en(gray_en), .ld(ld), .ld_val(ld_val),
        .q(a_q), .bin(a_bin), .tc(a_tc), .all_ones(a_all_ones),
        .busy(a_busy), .done(a_done)
    );

    moore_seq_gen #(.WIDTH(3), .MAX_VAL(5), .ONESHOT(1)) u_dut_b (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .dir(dir),
        .gray_en(gray_en), .ld(ld), .ld_val(ld_val),
        .q(b_q), .bin(b_bin), .tc(b_tc), .all_ones(b_all_ones),
        .busy(b_busy), .done(b_done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_a_q"}, 32'(a_q), 32'd0);
        chk({tag, "_a_bin"}, 32'(a_bin), 32'd0);
        chk({tag, "_a_flags"}, {28'd0, a_tc, a_all_ones, a_busy, a_done}, 32'd0);
        chk({tag, "_b_q"}, 32'(b_q), 32'd0);
        chk({tag, "_b_bin"}, 32'(b_bin), 32'd0);
        chk({tag, "_b_flags"}, {28'd0, b_tc, b_all_ones, b_busy, b_done}, 32'd0);
    endtask

    logic [2:0] gray_tab [9] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110,
                                 3'b111, 3'b101, 3'b100, 3'b000};
    logic [2:0] prev_q;

    initial begin
        tick();
        tick();
        rst = 1'b0;
        chk_all_zero("reset");

        // Binary up count on A; B counts 0..5 then stops in DONE.
        start = 1'b1; dir = 1'b0; gray_en = 1'b0;
        tick();
        start = 1'b0;
        for (int i = 0; i < 9; i++) begin
            chk("up_bin", 32'(a_bin), 32'(i % 8));
            chk("up_tc", 32'(a_tc), 32'(i == 7));
            chk("up_all_ones", 32'(a_all_ones), 32'(i == 7));
            if (i < 9) chk("b_up_bin", 32'(b_bin), 32'((i < 6) ? i : 5));
            if (i < 8) tick();
        end
        chk("b_oneshot_done", 32'(b_done), 32'd1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("stop_a_busy", 32'(a_busy), 32'd0);
        chk("stop_a_hold", 32'(a_bin), 32'd0);
        chk("stop_b_done", {30'd0, b_busy, b_done}, 32'd0);
        chk("stop_b_hold", 32'(b_bin), 32'd5);

        // Gray up count on A.
        start = 1'b1; dir = 1'b0; gray_en = 1'b1;
        tick();
        start = 1'b0;
        prev_q = a_q;
        for (int i = 0; i < 9; i++) begin
            chk("gray_q", 32'(a_q), 32'(gray_tab[i]));
            chk("gray_bin", 32'(a_bin), 32'(i % 8));
            if (i > 0) chk("gray_1bit", $countones(a_q ^ prev_q), 32'd1);
            prev_q = a_q;
            if (i < 8) tick();
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;

        // One-shot down count on B.
        start = 1'b1; dir = 1'b1; gray_en = 1'b0;
        tick();
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            chk("dn_bin", 32'(b_bin), 32'(5 - i));
            chk("dn_tc", 32'(b_tc), 32'(i == 5));
            chk("dn_busy", 32'(b_busy), 32'd1);
            tick();
        end
        chk("dn_done", {30'd0, b_busy, b_done}, 32'd1);
        chk("dn_hold", 32'(b_bin), 32'd0);
        tick();
        chk("dn_hold2", 32'(b_bin), 32'd0);
        start = 1'b1; dir = 1'b1;
        tick();
        start = 1'b0;
        chk("restart_bin", 32'(b_bin), 32'd5);
        chk("restart_busy", 32'(b_busy), 32'd1);
        stop = 1'b1;
        tick();
        stop = 1'b0;

        // Load clamps to MAX_VAL and suppresses the step.
        start = 1'b1; dir = 1'b0;
        tick();
        start = 1'b0;
        tick();
        chk("pre_ld_b", 32'(b_bin), 32'd1);
        ld = 1'b1; ld_val = 3'd7;
        tick();
        ld = 1'b0;
        chk("ld_clamp_b", 32'(b_bin), 32'd5);
        chk("ld_busy_b", 32'(b_busy), 32'd1);
        chk("ld_tc_b", 32'(b_tc), 32'd1);
        chk("ld_a", 32'(a_bin), 32'd7);
        tick();
        chk("ld_then_done_b", 32'(b_done), 32'd1);
        chk("ld_then_wrap_a", 32'(a_bin), 32'd0);
        start = 1'b1; dir = 1'b0;
        tick();
        start = 1'b0;
        chk("b_run_again", 32'(b_bin), 32'd0);
        chk("a_start_in_run", 32'(a_bin), 32'd1);
        ld = 1'b1; ld_val = 3'd2; stop = 1'b1;
        tick();
        ld = 1'b0; stop = 1'b0;
        chk("ld_stop_b_bin", 32'(b_bin), 32'd2);
        chk("ld_stop_b_st", {30'd0, b_busy, b_done}, 32'd0);
        chk("ld_stop_a_bin", 32'(a_bin), 32'd2);
        chk("ld_stop_a_busy", 32'(a_busy), 32'd0);

        // Reset mid-run, then start+stop together in IDLE.
        start = 1'b1; dir = 1'b0; gray_en = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        chk("mid_bin", 32'(a_bin), 32'd4);
        chk("mid_q", 32'(a_q), 32'd6);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_all_zero("midrst");
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        chk("ss_idle_a", {30'd0, a_busy, a_done}, 32'd0);
        chk("ss_idle_b", {30'd0, b_busy, b_done}, 32'd0);
        ld = 1'b1; ld_val = 3'd3;
        tick();
        ld = 1'b0;
        chk("idle_ld_bin", 32'(a_bin), 32'd3);
        chk("gray_cleared_q", 32'(a_q), 32'd3);

        // Start while busy with dir toggled is ignored.
        start = 1'b1; dir = 1'b0; gray_en = 1'b0;
        tick();
        start = 1'b0;
        chk("ign_0", 32'(a_bin), 32'd0);
        tick();
        chk("ign_1", 32'(a_bin), 32'd1);
        start = 1'b1; dir = 1'b1;
        tick();
        start = 1'b0; dir = 1'b0;
        chk("ign_2", 32'(a_bin), 32'd2);
        tick();
        chk("ign_3", 32'(a_bin), 32'd3);
        chk("ign_tc", 32'(a_tc), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
